// File: rtl/icache_controller_if.sv
// CPU fetch and instruction-memory refill signals of the instruction cache.
interface icache_controller_if #(
   parameter int unsigned ADDR_W = 10
);
   logic                INSTR_READ;
   logic [ADDR_W-1:0]   PC_ADDRESS;
   logic [31:0]         INSTRUCTION;
   logic                BUSYWAIT;
   logic                MEM_READ;
   logic [ADDR_W-5:0]   MEM_ADDRESS;
   logic [127:0]        MEM_READDATA;
   logic                MEM_BUSYWAIT;

   // Cache-side view: fetch requests and refill data come in.
   modport slave (
      input  INSTR_READ,
      input  PC_ADDRESS,
      input  MEM_READDATA,
      input  MEM_BUSYWAIT,
      output INSTRUCTION,
      output BUSYWAIT,
      output MEM_READ,
      output MEM_ADDRESS
   );

   // Environment-side view: CPU and instruction memory together.
   modport master (
      output INSTR_READ,
      output PC_ADDRESS,
      output MEM_READDATA,
      output MEM_BUSYWAIT,
      input  INSTRUCTION,
      input  BUSYWAIT,
      input  MEM_READ,
      input  MEM_ADDRESS
   );
endinterface

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache, 4-word blocks, single-block refill on miss.
module icache_controller #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned INDEX_W = 3
) (
   input logic                CLK,
   input logic                RESET,
   icache_controller_if.slave bus
);

   localparam int unsigned TAG_W = ADDR_W - 4 - INDEX_W;
   localparam int unsigned BLK_W = ADDR_W - 4;
   localparam int unsigned NBLK  = 2 ** INDEX_W;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_READ = 2'd1,
      S_UPDATE   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [BLK_W-1:0]    blk_addr_q, blk_addr_d;
   logic [NBLK-1:0]     valid_q, valid_d;
   logic                mem_read_q, mem_read_d;

   logic [TAG_W-1:0]    tag_q  [NBLK];
   logic [127:0]        data_q [NBLK];

   logic [TAG_W-1:0]    pc_tag;
   logic [INDEX_W-1:0]  pc_idx;
   logic [1:0]          pc_word;
   logic [INDEX_W-1:0]  blk_idx;
   logic [TAG_W-1:0]    blk_tag;
   logic                hit_c;
   logic                refill_we_c;
   logic [31:0]         word_c;
   logic                unused_pc_bits;

   assign pc_tag  = bus.PC_ADDRESS[ADDR_W-1:4+INDEX_W];
   assign pc_idx  = bus.PC_ADDRESS[3+INDEX_W:4];
   assign pc_word = bus.PC_ADDRESS[3:2];
   assign blk_idx = blk_addr_q[INDEX_W-1:0];
   assign blk_tag = blk_addr_q[BLK_W-1:INDEX_W];

   // Byte offset within a word is irrelevant for word-aligned fetches.
   assign unused_pc_bits = ^bus.PC_ADDRESS[1:0];

   // Tag lookup for the current PC.
   assign hit_c = bus.INSTR_READ & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);

   // The block is written on the edge where memory drops its busywait.
   assign refill_we_c = (state_q == S_MEM_READ) & ~bus.MEM_BUSYWAIT;

   // Word select from the indexed block.
   always_comb begin
      word_c = 32'h0;
      case (pc_word)
         2'd0:    word_c = data_q[pc_idx][31:0];
         2'd1:    word_c = data_q[pc_idx][63:32];
         2'd2:    word_c = data_q[pc_idx][95:64];
         default: word_c = data_q[pc_idx][127:96];
      endcase
   end

   // Instruction is only presented on a zero-stall hit in IDLE.
   assign bus.INSTRUCTION = ((state_q == S_IDLE) && hit_c) ? word_c : 32'h0;

   // Stall on a fresh miss and throughout the refill; reset forces it low.
   assign bus.BUSYWAIT = RESET & ((state_q == S_IDLE) ? (bus.INSTR_READ & ~hit_c) : 1'b1);

   assign bus.MEM_READ    = mem_read_q;
   assign bus.MEM_ADDRESS = blk_addr_q;

   // Next-state, block-address latch and valid-bit update.
   always_comb begin
      state_d    = state_q;
      blk_addr_d = blk_addr_q;
      valid_d    = valid_q;
      case (state_q)
         S_IDLE: begin
            if (bus.INSTR_READ && !hit_c) begin
               blk_addr_d = {pc_tag, pc_idx};
               state_d    = S_MEM_READ;
            end
         end
         S_MEM_READ: begin
            if (!bus.MEM_BUSYWAIT) begin
               valid_d[blk_idx] = 1'b1;
               state_d          = S_UPDATE;
            end
         end
         S_UPDATE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      mem_read_d = (state_d == S_MEM_READ);
   end

   // Control state with asynchronous clear.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= S_IDLE;
         blk_addr_q <= '0;
         valid_q    <= '0;
         mem_read_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         blk_addr_q <= blk_addr_d;
         valid_q    <= valid_d;
         mem_read_q <= mem_read_d;
      end
   end

   // Tag and data arrays; contents are qualified by valid bits so no reset is needed.
   always_ff @(posedge CLK) begin
      if (refill_we_c) begin
         tag_q[blk_idx]  <= blk_tag;
         data_q[blk_idx] <= bus.MEM_READDATA;
      end
   end

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a latency-programmable instruction memory model.
module tb_icache_controller;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;
   int   lat;
   int   mem_cnt;

   icache_controller_if #(.ADDR_W(10)) bus ();

   icache_controller dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: MEM_READ lasts 'lat' cycles, busywait low in the last one.
   initial mem_cnt = 0;
   always @(posedge clk) begin
      if (!bus.MEM_READ) mem_cnt <= 0;
      else               mem_cnt <= mem_cnt + 1;
   end
   assign bus.MEM_BUSYWAIT = bus.MEM_READ & (mem_cnt < lat - 1);

   // Word w of block b holds 0x5A000000 | its own byte address.
   always_comb begin
      bus.MEM_READDATA = '0;
      for (int w = 0; w < 4; w++)
         bus.MEM_READDATA[w*32 +: 32] = 32'h5A00_0000 | {22'h0, bus.MEM_ADDRESS, 2'(w), 2'b00};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.INSTR_READ = 1'b0;
      rst_n = 1'b0;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Fetch one PC; count stall cycles and memory reads, check result.
   task automatic fetch(input logic [9:0] pc, input int exp_stall, input string tag,
                        output int stall);
      int   reads;
      logic addr_ok;
      stall   = 0;
      reads   = 0;
      addr_ok = 1'b1;
      @(negedge clk);
      bus.INSTR_READ = 1'b1;
      bus.PC_ADDRESS = pc;
      #1;
      while (bus.BUSYWAIT && stall < 500) begin
         stall++;
         if (bus.MEM_READ) begin
            reads++;
            if (bus.MEM_ADDRESS !== pc[9:4]) addr_ok = 1'b0;
            if (bus.INSTRUCTION !== 32'h0)  addr_ok = 1'b0;
         end
         @(negedge clk);
         #1;
      end
      chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
      chk({tag, "_instr"}, bus.INSTRUCTION, 32'h5A00_0000 | {22'h0, pc});
      chk({tag, "_memrd_idle"}, 32'(bus.MEM_READ), 32'h0);
      if (exp_stall != 0) begin
         chk({tag, "_reads"}, 32'(reads), 32'(exp_stall - 2));
         chk({tag, "_addr"}, 32'(addr_ok), 32'h1);
      end
   endtask

   initial begin
      int st;
      int misses;
      n_total = 0;
      n_bad   = 0;
      lat     = 5;
      rst_n   = 1'b0;
      bus.INSTR_READ = 1'b1;
      bus.PC_ADDRESS = 10'h004;

      // Reset state, with a request already pending
      #1;
      chk("rst_busywait", 32'(bus.BUSYWAIT), 32'h0);
      chk("rst_memread",  32'(bus.MEM_READ), 32'h0);
      chk("rst_memaddr",  32'(bus.MEM_ADDRESS), 32'h0);
      chk("rst_instr",    bus.INSTRUCTION, 32'h0);
      do_reset();

      // 1: reset between edges during MEM_READ aborts the refill
      lat = 50;
      @(negedge clk);
      bus.INSTR_READ = 1'b1;
      bus.PC_ADDRESS = 10'h3F0;
      #1;
      chk("t1_miss_bw", 32'(bus.BUSYWAIT), 32'h1);
      @(negedge clk);
      #1;
      chk("t1_memread", 32'(bus.MEM_READ), 32'h1);
      chk("t1_memaddr", 32'(bus.MEM_ADDRESS), 32'h3F);
      rst_n = 1'b0;
      #1;
      chk("t1_rst_memread", 32'(bus.MEM_READ), 32'h0);
      chk("t1_rst_bw",      32'(bus.BUSYWAIT), 32'h0);
      chk("t1_rst_memaddr", 32'(bus.MEM_ADDRESS), 32'h0);
      @(negedge clk);
      bus.INSTR_READ = 1'b0;
      rst_n = 1'b1;
      lat = 5;
      fetch(10'h000, 7, "t1_pc000", st);
      fetch(10'h3F0, 7, "t1_aborted_blk", st);

      // 2: cold miss with 5-cycle memory, then hit on neighbour word
      do_reset();
      fetch(10'h004, 7, "t2_cold", st);
      fetch(10'h008, 0, "t2_hit", st);

      // 3: conflict eviction on index 1
      fetch(10'h010, 7, "t3_fill", st);
      fetch(10'h090, 7, "t3_evict", st);
      fetch(10'h010, 7, "t3_refill", st);
      fetch(10'h014, 0, "t3_hit", st);

      // 4: no request for 10 cycles, PC wandering over cached and uncached lines
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.INSTR_READ = 1'b0;
         bus.PC_ADDRESS = 10'(i * 36);
         #1;
         chk("t4_bw",      32'(bus.BUSYWAIT), 32'h0);
         chk("t4_memread", 32'(bus.MEM_READ), 32'h0);
         chk("t4_instr",   bus.INSTRUCTION, 32'h0);
      end

      // 5: extended memory stall, 20 cycles of MEM_READ held on block 6'h15
      lat = 20;
      fetch(10'h158, 22, "t5_long", st);
      lat = 5;
      fetch(10'h150, 0, "t5_hit", st);

      // 6: sequential sweep of 32 words, two passes
      do_reset();
      lat = 3;
      misses = 0;
      for (int i = 0; i < 32; i++) begin
         fetch(10'(i * 4), (i % 4 == 0) ? 5 : 0, "t6_p1", st);
         if (st != 0) misses++;
      end
      chk("t6_p1_misses", 32'(misses), 32'd8);
      misses = 0;
      for (int i = 0; i < 32; i++) begin
         fetch(10'(i * 4), 0, "t6_p2", st);
         if (st != 0) misses++;
      end
      chk("t6_p2_misses", 32'(misses), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
